// File: rtl/clk_div_pkg.sv
// -----------------------------------------------------------------------------
// clk_div_pkg
// Shared definitions for the multi-channel clock divider.
//   CNT_W_DEF    default divisor/counter width
//   DEF_DIV_DEF  default divisor loaded into every channel at reset
//   ld_req_t     pending load request {ch, div}, sized for the largest build
//                (up to 16 channels, up to 32-bit divisors)
//   half_hi()    number of cycles the square output stays high: div-(div>>1)
// -----------------------------------------------------------------------------
package clk_div_pkg;

    localparam int CNT_W_DEF    = 27;
    localparam int DEF_DIV_DEF  = 50000000;
    localparam int LD_CH_MAX_W  = 4;
    localparam int LD_DIV_MAX_W = 32;

    typedef struct packed {
        logic [LD_CH_MAX_W-1:0]  ch;
        logic [LD_DIV_MAX_W-1:0] div;
    } ld_req_t;

    // ceil(div/2) without a divider or an adder carry beyond the div width
    function automatic logic [LD_DIV_MAX_W-1:0] half_hi(input logic [LD_DIV_MAX_W-1:0] div);
        return div - (div >> 1);
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// -----------------------------------------------------------------------------
// clk_div_chan
// One divider channel: counter, active divisor, registered tick and square
// outputs. A new divisor is taken whenever adopt_i is high at a clock edge;
// the counter then restarts at 0.
// Optional feature: CLK_DIV_SYNC_EN adds sync_i, which clears cnt/tick/sq.
// Ports:
//   clk_i       system clock
//   clr_i       synchronous active-high reset
//   en_i        run enable; 0 freezes the counter
//   sync_i      (CLK_DIV_SYNC_EN only) phase restart
//   adopt_i     take div_i as the new divisor at this edge
//   div_i       divisor to adopt
//   term_o      counter is at its terminal count and running (combinational)
//   div_zero_o  channel currently disabled (combinational)
//   tick_o      one-cycle pulse per period (registered)
//   sq_o        square output, high for ceil(div/2) cycles (registered)
// -----------------------------------------------------------------------------
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int DEF_DIV = DEF_DIV_DEF
) (
    input  logic             clk_i,
    input  logic             clr_i,
    input  logic             en_i,
`ifdef CLK_DIV_SYNC_EN
    input  logic             sync_i,
`endif
    input  logic             adopt_i,
    input  logic [CNT_W-1:0] div_i,
    output logic             term_o,
    output logic             div_zero_o,
    output logic             tick_o,
    output logic             sq_o
);

    localparam logic [CNT_W-1:0] ONE     = (CNT_W)'(1);
    localparam logic [CNT_W-1:0] DIV_RST = (CNT_W)'(DEF_DIV);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic             tick_q, tick_d;
    logic             sq_q, sq_d;

    logic             div_nz;
    logic             at_end;
    logic [CNT_W-1:0] half;

    assign div_nz     = (div_q != '0);
    assign at_end     = div_nz && (cnt_q == div_q - ONE);
    assign half       = (CNT_W)'(half_hi((LD_DIV_MAX_W)'(div_q)));
    assign term_o     = en_i && at_end;
    assign div_zero_o = ~div_nz;
    assign tick_o     = tick_q;
    assign sq_o       = sq_q;

    always_comb begin
        cnt_d  = cnt_q;
        div_d  = div_q;
        tick_d = 1'b0;
        sq_d   = sq_q;
        if (en_i) begin
            tick_d = at_end;
            sq_d   = div_nz && (cnt_q < half);
            cnt_d  = (!div_nz || at_end) ? '0 : cnt_q + ONE;
        end else if (!div_nz) begin
            // a disabled channel never shows a stale high level, even while frozen
            sq_d = 1'b0;
        end
`ifdef CLK_DIV_SYNC_EN
        if (sync_i) begin
            cnt_d  = '0;
            tick_d = 1'b0;
            sq_d   = 1'b0;
        end
`endif
        // outputs above were computed from the old divisor: a tick coinciding
        // with adoption still belongs to the old period
        if (adopt_i) begin
            div_d = div_i;
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            cnt_q  <= '0;
            div_q  <= DIV_RST;
            tick_q <= 1'b0;
            sq_q   <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            div_q  <= div_d;
            tick_q <= tick_d;
            sq_q   <= sq_d;
        end
    end

endmodule

// File: rtl/clk_div_multi.sv
// -----------------------------------------------------------------------------
// clk_div_multi
// CH independent divider channels with run-time programmable divisors.
// One shared pending-load slot: a load accepted on ld_vld && ld_rdy is held
// until its channel reaches terminal count (or immediately if the old or new
// divisor is 0), then the channel restarts with the new divisor.
// Optional feature: define CLK_DIV_SYNC_EN to add input `sync` (after `en`),
// which restarts all channels in phase and adopts a pending load at once.
// Ports:
//   clk     system clock, rising edge
//   clr     synchronous active-high reset
//   en      global run; 0 freezes all counters
//   sync    (CLK_DIV_SYNC_EN only) phase-align all channels
//   ld_vld  divisor load request
//   ld_rdy  load slot free
//   ld_ch   target channel (values >= CH are accepted and dropped)
//   ld_div  new divisor; 0 disables the channel
//   tick    per-channel single-cycle pulse once per period
//   sq      per-channel square wave
// -----------------------------------------------------------------------------
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter  int CH      = 4,
    parameter  int CNT_W   = CNT_W_DEF,
    parameter  int DEF_DIV = DEF_DIV_DEF,
    localparam int CH_W    = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
`ifdef CLK_DIV_SYNC_EN
    input  logic             sync,
`endif
    input  logic             ld_vld,
    output logic             ld_rdy,
    input  logic [CH_W-1:0]  ld_ch,
    input  logic [CNT_W-1:0] ld_div,
    output logic [CH-1:0]    tick,
    output logic [CH-1:0]    sq
);

    ld_req_t          pend_q, pend_d;
    logic             pend_vld_q, pend_vld_d;
    logic [CH-1:0]    term;
    logic [CH-1:0]    div_zero;
    logic [CH-1:0]    adopt;
    logic [CNT_W-1:0] pend_div;
    logic             pend_div_zero;
    logic             accept;
    logic             ld_ch_ok;
    logic             sync_now;

`ifdef CLK_DIV_SYNC_EN
    assign sync_now = sync;
`else
    assign sync_now = 1'b0;
`endif

    assign ld_rdy        = ~pend_vld_q;
    assign accept        = ld_vld && ld_rdy;
    assign ld_ch_ok      = (int'(ld_ch) < CH);
    assign pend_div      = (CNT_W)'(pend_q.div);
    assign pend_div_zero = (pend_div == '0);

    for (genvar i = 0; i < CH; i++) begin : g_chan
        assign adopt[i] = pend_vld_q && (pend_q.ch == (LD_CH_MAX_W)'(i)) &&
                          (sync_now || term[i] || div_zero[i] || pend_div_zero);

        clk_div_chan #(
            .CNT_W   (CNT_W),
            .DEF_DIV (DEF_DIV)
        ) u_chan (
            .clk_i      (clk),
            .clr_i      (clr),
            .en_i       (en),
`ifdef CLK_DIV_SYNC_EN
            .sync_i     (sync),
`endif
            .adopt_i    (adopt[i]),
            .div_i      (pend_div),
            .term_o     (term[i]),
            .div_zero_o (div_zero[i]),
            .tick_o     (tick[i]),
            .sq_o       (sq[i])
        );
    end

    // accept and adopt are mutually exclusive: accept needs an empty slot,
    // adopt needs a full one
    always_comb begin
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        if (accept && ld_ch_ok) begin
            pend_vld_d = 1'b1;
            pend_d.ch  = (LD_CH_MAX_W)'(ld_ch);
            pend_d.div = (LD_DIV_MAX_W)'(ld_div);
        end else if (|adopt) begin
            pend_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            pend_vld_q <= 1'b0;
        end else begin
            pend_vld_q <= pend_vld_d;
        end
    end

    // request payload is qualified by pend_vld_q, so it needs no reset
    always_ff @(posedge clk) begin
        pend_q <= pend_d;
    end

endmodule
